// File: rtl/parity_frame_checker.sv
// parity_frame_checker: frames a stream of 9-bit words and tallies parity errors
// reported by an external 9-bit parity checker (pe/po).
// Optional build macro PARITY_FAULT_CHECK_EN adds a local parity cross-check.
// That check raises a sticky fault whenever the external checker disagrees with
// itself or with the data word.
module parity_frame_checker #(
  parameter int FRAME_LEN = 16,
  parameter int ERR_W     = 8,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             enable,
  input  logic [8:0]       data,
  input  logic             pe,
  input  logic             po,
  input  logic             odd_mode,
  output logic             busy,
  output logic [IDX_W-1:0] word_idx,
  output logic             frame_done,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             fault_q, fault_d;

  logic             parity_ok;
  logic             fault_hit;
  logic             word_bad;
  logic             last_word;

`ifdef PARITY_FAULT_CHECK_EN
  logic local_pe;
  // The even-parity flag is high when data carries an even number of ones.
  // pe and po must always be complementary and pe must agree with our own XNOR.
  assign local_pe  = ~^data;
  assign fault_hit = (pe == po) || (pe != local_pe);
`else
  logic [8:0] unused_data;
  // Without the cross-check the data word itself is not needed.
  assign unused_data = data;
  assign fault_hit   = 1'b0;
`endif

  assign parity_ok = odd_mode ? po : pe;
  assign word_bad  = !parity_ok || fault_hit;
  assign last_word = (word_idx_q == IDX_W'(FRAME_LEN - 1));

  // Next-state and next-output logic; every accepted word updates the error
  // tally and fault flag regardless of which state accepts it.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    acc_d        = acc_q;
    frame_err_d  = frame_err_q;
    err_count_d  = err_count_q;
    fault_d      = fault_q;

    if (enable) begin
      if (word_bad && (err_count_q != {ERR_W{1'b1}})) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
      if (fault_hit) begin
        fault_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (enable) begin
          state_d    = RUN;
          word_idx_d = IDX_W'(1);
          acc_d      = word_bad;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
        if (enable) begin
          if (last_word) begin
            state_d     = DONE;
            word_idx_d  = '0;
            acc_d       = 1'b0;
            frame_err_d = acc_q || word_bad;
          end else begin
            word_idx_d  = word_idx_q + IDX_W'(1);
            acc_d       = acc_q || word_bad;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        word_idx_d = '0;
        acc_d      = 1'b0;
      end
    endcase

    // busy covers the one-cycle DONE slot too, so back-to-back frames keep it high.
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  // State and output registers; clear_n discards any partial frame immediately.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      acc_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
      fault_q      <= fault_d;
    end
  end

  assign busy       = busy_q;
  assign word_idx   = word_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign fault      = fault_q;

endmodule
